// File: rtl/beep_tone_driver.sv
// beep_tone_driver: turns a level beep gate into a square-wave buzzer tone.
// Bursts start on a rising half and always end after a complete low half.
// Optional macro BUZZ_CYCLE_CNT_EN adds a saturating completed-period counter.
module beep_tone_driver #(
    parameter int unsigned DIV0  = 25000,
    parameter int unsigned DIV1  = 12500,
    parameter int unsigned DIV2  = 6250,
    parameter int unsigned DIV3  = 50000,
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beep,
    input  logic [1:0] tone_sel,
    output logic       buzz,
    output logic       busy,
    output logic [1:0] tone_act
`ifdef BUZZ_CYCLE_CNT_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic [1:0]         tone_q, tone_d;
    logic               buzz_q, buzz_d;
    logic               busy_q;
    logic               last_half_cyc;
    logic               period_end;

    // Half-period for a tone select; 0 or 1 would give no square wave, so clamp to 2.
    function automatic logic [CNT_W-1:0] half_of(input logic [1:0] sel);
        int unsigned d;
        case (sel)
            2'd0:    d = DIV0;
            2'd1:    d = DIV1;
            2'd2:    d = DIV2;
            default: d = DIV3;
        endcase
        if (d < 2) d = 2;
        return d[CNT_W-1:0];
    endfunction

    assign last_half_cyc = (cnt_q == half_q - CNT_W'(1));
    assign period_end    = last_half_cyc && !buzz_q;

    // Next-state: counter/toggle run in RUN and STOP; tone only re-latched at period ends.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        tone_d  = tone_q;
        buzz_d  = buzz_q;
        case (state_q)
            IDLE: begin
                buzz_d = 1'b0;
                cnt_d  = '0;
                if (beep) begin
                    tone_d  = tone_sel;
                    half_d  = half_of(tone_sel);
                    buzz_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN, STOP: begin
                if (last_half_cyc) begin
                    cnt_d  = '0;
                    buzz_d = ~buzz_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (state_q == RUN) begin
                    if (period_end) begin
                        if (beep) begin
                            buzz_d = 1'b1;
                            tone_d = tone_sel;
                            half_d = half_of(tone_sel);
                        end else begin
                            buzz_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else if (!beep) begin
                        state_d = STOP;
                    end
                end else if (period_end) begin
                    buzz_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                buzz_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; busy tracks the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            tone_q  <= 2'd0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            tone_q  <= tone_d;
            buzz_q  <= buzz_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign buzz     = buzz_q;
    assign busy     = busy_q;
    assign tone_act = tone_q;

`ifdef BUZZ_CYCLE_CNT_EN
    logic [15:0] ccnt_q, ccnt_d;

    // Completed periods in the current burst, saturating; cleared at burst start.
    always_comb begin
        ccnt_d = ccnt_q;
        if (state_q == IDLE) begin
            if (beep) ccnt_d = '0;
        end else if (period_end && ccnt_q != 16'hFFFF) begin
            ccnt_d = ccnt_q + 16'd1;
        end
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (rst) ccnt_q <= '0;
        else     ccnt_q <= ccnt_d;
    end

    assign cycle_cnt = ccnt_q;
`endif

endmodule
